// File: rtl/network_mod_frame_arb.sv
// Round-robin frame arbiter: grants one requester per frame and holds it until EOF.
// Optional idle watchdog is compiled in with NETWORK_MOD_FRAME_ARB_WATCHDOG_EN.
module network_mod_frame_arb #(
    parameter int CHANNELS = 4,
    parameter int TIMEOUT  = 1024,
    localparam int IDX_W   = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] req,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                xfer_vld,
    input  logic                xfer_eof,
    input  logic                err_clr,
    output logic [CHANNELS-1:0] grant,
    output logic                grant_vld,
    output logic [IDX_W-1:0]    grant_idx,
    output logic [31:0]         stat_frames,
    output logic [CHANNELS-1:0] timeout_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [IDX_W-1:0]    last_idx;
    logic [CHANNELS-1:0] eligible;
    logic [IDX_W-1:0]    arb_ptr;
    logic [IDX_W-1:0]    pick;
    logic                found;
    logic                eof_release;
    logic                timeout_hit;
    logic                release_now;

    // Returns {found, index} of the first set bit strictly after ptr, wrapping.
    function automatic logic [IDX_W:0] next_grant(input logic [CHANNELS-1:0] elig,
                                                  input logic [IDX_W-1:0]    ptr);
        logic [IDX_W:0] res;
        int             cand;
        res = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = (int'(ptr) + k) % CHANNELS;
            if (!res[IDX_W] && elig[cand]) begin
                res = {1'b1, IDX_W'(cand)};
            end
        end
        return res;
    endfunction

    // NOTE: every combinational output gets a value before any branch so no latch is inferred.
    always_comb begin
        eligible = req & ch_en;
        // On a release cycle the pointer is the channel being released.
        arb_ptr  = (state == BUSY) ? grant_idx : last_idx;
        {found, pick} = next_grant(eligible, arb_ptr);
    end

    assign eof_release = (state == BUSY) && xfer_vld && xfer_eof;
    assign release_now = eof_release || timeout_hit;

`ifdef NETWORK_MOD_FRAME_ARB_WATCHDOG_EN
    logic [15:0] wd_cnt;

    assign timeout_hit = (state == BUSY) && !xfer_vld && (wd_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= '0;
        end else begin
            if (state == IDLE || xfer_vld || release_now) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            // A set on the same cycle as a clear must win.
            timeout_err <= (timeout_err & ~{CHANNELS{err_clr}}) |
                           (timeout_hit ? grant : '0);
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign timeout_hit    = 1'b0;
    assign timeout_err    = '0;
`endif

    // NOTE: state and outputs update with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_vld   <= 1'b0;
            grant_idx   <= '0;
            last_idx    <= IDX_W'(CHANNELS - 1);
            stat_frames <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= BUSY;
                        grant     <= {{(CHANNELS-1){1'b0}}, 1'b1} << pick;
                        grant_vld <= 1'b1;
                        grant_idx <= pick;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        last_idx <= grant_idx;
                        if (eof_release) begin
                            stat_frames <= stat_frames + 32'd1;
                        end
                        if (found) begin
                            grant     <= {{(CHANNELS-1){1'b0}}, 1'b1} << pick;
                            grant_vld <= 1'b1;
                            grant_idx <= pick;
                        end else begin
                            state     <= IDLE;
                            grant     <= '0;
                            grant_vld <= 1'b0;
                            grant_idx <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/network_mod_frame_arb.md
NETWORK_MOD_FRAME_ARB -- requirements
Module: network_mod_frame_arb

Interface
REQ-001 Parameter CHANNELS, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter TIMEOUT, default 1024, watchdog idle-cycle limit; legal range 2..65535.
REQ-003 CLK  in  1  single clock for all logic.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 REQ  in  CHANNELS  per-channel "frame pending" request.
REQ-006 CH_EN  in  CHANNELS  per-channel arbitration enable mask.
REQ-007 XFER_VLD  in  1  one beat accepted on the shared datapath this cycle (SRC_RDY and DST_RDY of the granted channel).
REQ-008 XFER_EOF  in  1  the accepted beat carries EOF; qualified by XFER_VLD.
REQ-009 ERR_CLR  in  1  clears TIMEOUT_ERR.
REQ-010 GRANT  out  CHANNELS  one-hot grant; all zero when idle.
REQ-011 GRANT_VLD  out  1  OR of GRANT.
REQ-012 GRANT_IDX  out  clog2(CHANNELS)  index of the granted channel; 0 when idle.
REQ-013 STAT_FRAMES  out  32  count of frames completed by EOF.
REQ-014 TIMEOUT_ERR  out  CHANNELS  sticky per-channel watchdog flags.

Function
REQ-015 The FSM SHALL have two states, IDLE and BUSY; GRANT, GRANT_VLD and GRANT_IDX SHALL be registered outputs.
REQ-016 Eligible set = REQ AND CH_EN.
REQ-017 In IDLE with a non-empty eligible set, the block SHALL select the first eligible index strictly after LAST_IDX, wrapping modulo CHANNELS, and SHALL enter BUSY with GRANT valid on the next cycle (1-cycle latency).
REQ-018 In BUSY, GRANT SHALL hold regardless of changes on REQ or CH_EN until release, preserving frame integrity.
REQ-019 Release SHALL occur on XFER_VLD=1 and XFER_EOF=1 in BUSY; LAST_IDX SHALL become the released index.
REQ-020 On the release cycle the block SHALL re-arbitrate using the updated pointer; if the eligible set is non-empty, the new GRANT SHALL appear on the next cycle with no idle bubble; otherwise it SHALL return to IDLE.
REQ-021 The released channel SHALL be regranted back-to-back only when it is the sole eligible channel.
REQ-022 XFER_VLD in IDLE SHALL be ignored and SHALL cause no state change or count.
REQ-023 STAT_FRAMES SHALL increment by 1 per EOF release and SHALL wrap 0xFFFFFFFF -> 0.
REQ-024 A TIMEOUT_ERR bit SHALL set and stay set until ERR_CLR; on a simultaneous set and ERR_CLR, set SHALL win for that bit.

Reset
REQ-025 On RESET=1 at a CLK edge, the block SHALL apply: state IDLE, GRANT=0, GRANT_VLD=0, GRANT_IDX=0, LAST_IDX=CHANNELS-1 (so channel 0 wins first), STAT_FRAMES=0, TIMEOUT_ERR=0, watchdog=0.
REQ-026 A reset in mid-frame SHALL drop the grant on the next cycle without counting the frame.
REQ-027 RESET SHALL take priority over every other input.

Configuration
REQ-028 Macro NETWORK_MOD_FRAME_ARB_WATCHDOG_EN SHALL control the watchdog.
REQ-029 With the macro defined, a 16-bit counter SHALL clear on entry to BUSY and on every XFER_VLD, and SHALL increment on each BUSY cycle without XFER_VLD.
REQ-030 With the macro defined, when the counter reaches TIMEOUT-1 the block SHALL force a release as per REQ-019/020, set TIMEOUT_ERR[GRANT_IDX], and not increment STAT_FRAMES.
REQ-031 With the macro undefined, there SHALL be no counter and no forced release, TIMEOUT_ERR SHALL be tied to 0, and ERR_CLR SHALL be ignored.

Verification
REQ-032 Reset, then REQ=0b1111, CH_EN=0b1111, each frame 3 beats ending with EOF -> grant order 0,1,2,3,0; GRANT_IDX valid 1 cycle after REQ; no gap between frames; STAT_FRAMES=5 after 5 frames.
REQ-033 Grant ch2 mid-frame, then drop CH_EN[2] and REQ[2] -> GRANT stays 0b0100 until EOF; the next grant skips ch2.
REQ-034 Only REQ[1]=1 across 4 consecutive frames -> ch1 granted back-to-back with no bubble; STAT_FRAMES=4.
REQ-035 Preload STAT_FRAMES to 0xFFFFFFFF via back-door force, then complete one EOF -> STAT_FRAMES=0.
REQ-036 Macro defined, TIMEOUT=8: grant ch3, no XFER_VLD for 8 cycles -> grant dropped on cycle 8, TIMEOUT_ERR=0b1000, STAT_FRAMES unchanged; ERR_CLR asserted on the same cycle as the set -> bit remains 1; ERR_CLR on a later cycle -> 0.
REQ-037 Assert RESET in BUSY mid-frame -> GRANT=0 on the next cycle, STAT_FRAMES=0; first post-reset grant goes to ch0.
